// File: rtl/fifo1_reg.sv
// Depth-1 registered FIFO: one valid bit plus one data register, all outputs registered.
// Optional simulation-only protocol checker reports overflow and underflow.
module fifo1_reg #(
    parameter int unsigned width   = 1,
    parameter bit          guarded = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [width-1:0] D_IN,
    input  logic             ENQ,
    input  logic             DEQ,
    input  logic             CLR,
    output logic [width-1:0] D_OUT,
    output logic             EMPTY_N,
    output logic             FULL_N
);

    logic             full_reg;
    logic [width-1:0] data_reg;

    // CLR outranks ENQ, which outranks DEQ; data keeps its stale value when emptied.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            full_reg <= 1'b0;
            data_reg <= '0;
        end else begin
            if (CLR)
                full_reg <= 1'b0;
            else if (ENQ)
                full_reg <= 1'b1;
            else if (DEQ)
                full_reg <= 1'b0;

            if (ENQ && !CLR)
                data_reg <= D_IN;
        end
    end

    assign D_OUT   = data_reg;
    assign EMPTY_N = full_reg;
    assign FULL_N  = ~full_reg;

    generate
        if (guarded) begin : g_check
            always_ff @(posedge CLK) begin
                if (RST && !CLR) begin
                    if (ENQ && !DEQ && full_reg)
                        $info("FIFO1 enq on full %m");
                    if (DEQ && !ENQ && !full_reg)
                        $info("FIFO1 deq on empty %m");
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fifo1_reg.sv
// Scoreboarded random bench for fifo1_reg against a queue-based depth-1 reference model.
module tb_fifo1_reg;

    localparam int unsigned W = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic [W-1:0] D_IN = '0;
    logic         ENQ = 1'b0;
    logic         DEQ = 1'b0;
    logic         CLR = 1'b0;
    logic [W-1:0] D_OUT;
    logic         EMPTY_N;
    logic         FULL_N;

    fifo1_reg #(.width(W), .guarded(1'b1)) dut (
        .CLK(CLK), .RST(RST), .D_IN(D_IN), .ENQ(ENQ), .DEQ(DEQ), .CLR(CLR),
        .D_OUT(D_OUT), .EMPTY_N(EMPTY_N), .FULL_N(FULL_N)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic         valid;
        logic [W-1:0] data;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] model_q[$];
    logic [W-1:0] last_data = '0;
    int           checks = 0;
    int           failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: FIFO of capacity one; the visible data is whatever was last written.
    task automatic model_edge(input logic enq, input logic deq, input logic clr, input logic [W-1:0] din);
        exp_t e;
        if (clr) begin
            model_q.delete();
        end else if (enq) begin
            if (deq && model_q.size() != 0)
                void'(model_q.pop_front());
            if (model_q.size() != 0)
                model_q.delete();
            model_q.push_back(din);
            last_data = din;
        end else if (deq && model_q.size() != 0) begin
            void'(model_q.pop_front());
        end
        e.valid = (model_q.size() != 0);
        e.data  = last_data;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic enq, input logic deq, input logic clr, input logic [W-1:0] din);
        @(negedge CLK);
        ENQ = enq; DEQ = deq; CLR = clr; D_IN = din;
        @(posedge CLK);
        model_edge(enq, deq, clr, din);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("empty_n", 32'(EMPTY_N), 32'(e.valid));
                chk("full_n", 32'(FULL_N), 32'(!e.valid));
                chk("d_out", 32'(D_OUT), 32'(e.data));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin : stim
        ENQ = 1'b1; D_IN = 8'h01;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            chk("rst_empty_n", 32'(EMPTY_N), 32'd0);
            chk("rst_full_n", 32'(FULL_N), 32'd1);
            chk("rst_d_out", 32'(D_OUT), 32'd0);
        end
        @(negedge CLK);
        RST = 1'b1; ENQ = 1'b0;

        step(1'b1, 1'b0, 1'b0, 8'h01);   // basic enqueue
        step(1'b0, 1'b1, 1'b0, 8'hEE);   // dequeue, stale data stays
        step(1'b1, 1'b0, 1'b0, 8'h5A);
        step(1'b1, 1'b1, 1'b0, 8'h00);   // full pass-through
        step(1'b1, 1'b0, 1'b1, 8'hFF);   // clear beats enqueue
        step(1'b0, 1'b1, 1'b0, 8'h33);   // underflow
        step(1'b1, 1'b0, 1'b0, 8'h11);
        step(1'b1, 1'b0, 1'b0, 8'h22);   // overflow overwrites
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h44);   // enq+deq while empty
        step(1'b0, 1'b0, 1'b0, 8'h99);   // hold

        @(negedge CLK);
        ENQ = 1'b0; DEQ = 1'b0; CLR = 1'b0;
        #1 RST = 1'b0;
        #1;
        chk("async_empty_n", 32'(EMPTY_N), 32'd0);
        chk("async_full_n", 32'(FULL_N), 32'd1);
        chk("async_d_out", 32'(D_OUT), 32'd0);
        #1 RST = 1'b1;
        model_q.delete();
        last_data = '0;
        step(1'b1, 1'b0, 1'b0, 8'h77);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < 8, W'($urandom));

        step(1'b0, 1'b0, 1'b0, 8'h00);
        @(posedge CLK);
        #2;
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo1_reg.md
Name: fifo1_reg

Overview:
- Single-entry (depth-1) registered FIFO with active-high occupancy flags EMPTY_N/FULL_N.
- Sits between a producer and a consumer as a one-stage elastic buffer.
- Data is held in an output register and presented on D_OUT whenever the entry is valid.
- Synchronous clear, asynchronous active-low reset, optional simulation-time protocol checking.

Parameters:
- width, 1, data width in bits of D_IN/D_OUT (legal range 1..1024).
- guarded, 1, when 1 the simulation-only checker reports ENQ-while-full and DEQ-while-empty; when 0 the checker is disabled (no effect on synthesised logic).

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST  input  1  asynchronous active-low reset.
- D_IN  input  width  enqueue data.
- ENQ  input  1  enqueue strobe; captures D_IN at the clock edge.
- DEQ  input  1  dequeue strobe; removes the stored entry at the clock edge.
- CLR  input  1  synchronous clear; empties the FIFO.
- D_OUT  output  width  stored entry, registered.
- EMPTY_N  output  1  1 = entry valid (not empty).
- FULL_N  output  1  1 = space available (not full).

Behaviour:
- State:
  - One valid bit (full_reg) and one data register (data_reg) of width bits.
  - EMPTY_N = full_reg; FULL_N = ~full_reg; D_OUT = data_reg.
  - All outputs are purely registered; no combinational path from any input to any output.
- Reset:
  - RST low asynchronously forces full_reg = 0 and data_reg = 0, regardless of CLK.
  - Gives EMPTY_N = 0, FULL_N = 1, D_OUT = 0 for the whole time RST is held low.
  - Deasserting RST takes effect at the next clock edge; the first enqueue is possible on the first edge with RST high.
- Valid-bit next state, evaluated on each rising CLK edge with RST high, highest priority first:
  - CLR = 1 -> full_reg <= 0.
  - else ENQ = 1 -> full_reg <= 1.
  - else DEQ = 1 -> full_reg <= 0.
  - else -> hold.
- Data register:
  - ENQ = 1 and CLR = 0 -> data_reg <= D_IN.
  - Otherwise data_reg holds. DEQ and CLR do not alter data_reg; the stale value remains visible on D_OUT while EMPTY_N = 0.
- Latency:
  - Data enqueued at edge N is on D_OUT with EMPTY_N = 1 immediately after edge N.
  - A dequeue at edge N clears EMPTY_N immediately after edge N.
- Simultaneous ENQ + DEQ:
  - When full: the old entry is consumed and the new one stored. FIFO stays full, D_OUT takes D_IN, flags unchanged.
  - When empty: ENQ wins; FIFO becomes full. The DEQ is a protocol violation.
- CLR with ENQ: CLR wins; FIFO empty, data not captured.
- ENQ while full and DEQ absent (overflow):
  - data_reg is overwritten and FIFO stays full.
  - If guarded = 1, a simulation message "FIFO1 enq on full" plus the instance path is displayed on that edge.
- DEQ while empty and ENQ absent (underflow):
  - No state change.
  - If guarded = 1, "FIFO1 deq on empty" is displayed.
- The checker is not evaluated during reset or when CLR = 1.
- Reset mid-operation: asserting RST at any time discards the held entry asynchronously; the flags return to empty.

Test Plan:
- Reset: hold RST = 0 for 3 cycles with ENQ = 1, D_IN = 1 -> EMPTY_N = 0, FULL_N = 1, D_OUT = 0 throughout.
- Basic enq/deq, width 1: ENQ with D_IN = 1 for one cycle -> EMPTY_N = 1, FULL_N = 0, D_OUT = 1. Then DEQ one cycle -> EMPTY_N = 0, FULL_N = 1.
- Full pass-through: FIFO holding 1, assert ENQ + DEQ with D_IN = 0 -> stays full, D_OUT = 0, no checker message.
- Clear priority: FIFO full, assert CLR + ENQ with D_IN = 1 -> EMPTY_N = 0, FULL_N = 1, D_OUT unchanged.
- Protocol errors with guarded = 1:
  - ENQ while full -> overflow message, D_OUT takes new value.
  - DEQ while empty -> underflow message, flags unchanged.
- Async reset mid-operation: FIFO full, pulse RST low between clock edges -> flags go empty and D_OUT = 0 before the next edge; the next ENQ works normally.
